// File: rtl/vc_tx_arbiter_if.sv
// Handshake and flow-control bundle between a two-VC source and the transmit
// arbiter. master drives the source side, slave is the arbiter.
interface vc_tx_arbiter_if #(
  parameter int BUS_SIZE = 5
);
  logic [BUS_SIZE-1:0] in_vc0_data;
  logic                in_vc0_valid;
  logic                in_vc0_ready;
  logic [BUS_SIZE-1:0] in_vc1_data;
  logic                in_vc1_valid;
  logic                in_vc1_ready;
  logic                pause_VC0;
  logic                continue_VC0;
  logic                pause_VC1;
  logic                continue_VC1;
  logic [BUS_SIZE:0]   data_p;
  logic                valid_p;
  logic                stalled_vc0;
  logic                stalled_vc1;
  logic                drop_err;

  modport master (
    output in_vc0_data, in_vc0_valid, in_vc1_data, in_vc1_valid,
    output pause_VC0, continue_VC0, pause_VC1, continue_VC1,
    input  in_vc0_ready, in_vc1_ready,
    input  data_p, valid_p, stalled_vc0, stalled_vc1, drop_err
  );

  modport slave (
    input  in_vc0_data, in_vc0_valid, in_vc1_data, in_vc1_valid,
    input  pause_VC0, continue_VC0, pause_VC1, continue_VC1,
    output in_vc0_ready, in_vc1_ready,
    output data_p, valid_p, stalled_vc0, stalled_vc1, drop_err
  );
endinterface

// File: rtl/vc_tx_arbiter.sv
// Two virtual-channel transmit arbiter: a small FIFO per VC, pause/continue
// stall flags from the downstream switch, and a round-robin pick of one word
// per cycle onto a registered {vc_id, payload} output.
module vc_tx_arbiter #(
  parameter int BUS_SIZE   = 5,
  parameter int ADDR_WIDTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  vc_tx_arbiter_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  // Per-VC views of the interface so both channels share one code path.
  logic [BUS_SIZE-1:0] in_data  [2];
  logic                in_valid [2];
  logic                pause    [2];
  logic                resume   [2];

  assign in_data[0]  = bus.in_vc0_data;
  assign in_data[1]  = bus.in_vc1_data;
  assign in_valid[0] = bus.in_vc0_valid;
  assign in_valid[1] = bus.in_vc1_valid;
  assign pause[0]    = bus.pause_VC0;
  assign pause[1]    = bus.pause_VC1;
  assign resume[0]   = bus.continue_VC0;
  assign resume[1]   = bus.continue_VC1;

  logic [BUS_SIZE-1:0]   fifo_mem [2][DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr   [2];
  logic [ADDR_WIDTH-1:0] rd_ptr   [2];
  logic [ADDR_WIDTH:0]   count    [2];
  logic                  stalled  [2];
  logic                  last_grant;
  logic [BUS_SIZE:0]     data_q;
  logic                  valid_q;
  logic                  drop_q;

  logic ready    [2];
  logic wr_en    [2];
  logic eligible [2];
  logic pop      [2];
  logic grant_vld;
  logic grant_vc;

  // Per-VC acceptance and eligibility from registered state plus this cycle's pause.
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      ready[v]    = (count[v] != FULL_COUNT);
      wr_en[v]    = in_valid[v] && ready[v];
      eligible[v] = (count[v] != '0) && !stalled[v] && !pause[v];
    end
  end

  // Round-robin pick: a lone eligible VC wins, a tie goes to the VC not granted last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    grant_vld = eligible[0] || eligible[1];
    grant_vc  = 1'b0;
    pop[0]    = 1'b0;
    pop[1]    = 1'b0;
    if (eligible[0] && eligible[1]) begin
      grant_vc = ~last_grant;
    end else begin
      grant_vc = eligible[1];
    end
    if (grant_vld) begin
      pop[0] = ~grant_vc;
      pop[1] = grant_vc;
    end
  end

  // Word storage.
  // NOTE: the storage array is deliberately not reset; occupancy counters make stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (!reset && wr_en[v]) begin
        fifo_mem[v][wr_ptr[v]] <= in_data[v];
      end
    end
  end

  // Pointers, occupancy, stall flags, arbitration history and the output register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      for (int v = 0; v < 2; v++) begin
        wr_ptr[v]  <= '0;
        rd_ptr[v]  <= '0;
        count[v]   <= '0;
        stalled[v] <= 1'b0;
      end
      last_grant <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + ADDR_WIDTH'(1);
        if (pop[v])   rd_ptr[v] <= rd_ptr[v] + ADDR_WIDTH'(1);
        case ({wr_en[v], pop[v]})
          2'b10:   count[v] <= count[v] + (ADDR_WIDTH + 1)'(1);
          2'b01:   count[v] <= count[v] - (ADDR_WIDTH + 1)'(1);
          default: count[v] <= count[v];
        endcase
        if (pause[v]) begin
          stalled[v] <= 1'b1;
        end else if (resume[v]) begin
          stalled[v] <= 1'b0;
        end
        if (in_valid[v] && !ready[v]) drop_q <= 1'b1;
      end
      if (grant_vld) begin
        last_grant <= grant_vc;
        data_q     <= {grant_vc, fifo_mem[grant_vc][rd_ptr[grant_vc]]};
        valid_q    <= 1'b1;
      end else begin
        valid_q    <= 1'b0;
      end
    end
  end

  assign bus.in_vc0_ready = ready[0];
  assign bus.in_vc1_ready = ready[1];
  assign bus.data_p       = data_q;
  assign bus.valid_p      = valid_q;
  assign bus.stalled_vc0  = stalled[0];
  assign bus.stalled_vc1  = stalled[1];
  assign bus.drop_err     = drop_q;
endmodule

// File: tb/tb_vc_tx_arbiter.sv
// Bench for vc_tx_arbiter: directed scenarios followed by random traffic, all
// compared cycle by cycle against a queue-based model of the channel rules.
module tb_vc_tx_arbiter;
  localparam int BS = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_tx_arbiter_if #(.BUS_SIZE(BS)) bus ();

  vc_tx_arbiter #(.BUS_SIZE(BS), .ADDR_WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: one queue per VC plus the visible flags.
  logic [BS-1:0] q0[$];
  logic [BS-1:0] q1[$];
  logic          m_stall0, m_stall1, m_last, m_valid, m_drop;
  logic [BS:0]   m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("valid_p",      32'(bus.valid_p),      32'(m_valid));
    check("data_p",       32'(bus.data_p),       32'(m_data));
    check("in_vc0_ready", 32'(bus.in_vc0_ready), 32'(q0.size() != 4));
    check("in_vc1_ready", 32'(bus.in_vc1_ready), 32'(q1.size() != 4));
    check("stalled_vc0",  32'(bus.stalled_vc0),  32'(m_stall0));
    check("stalled_vc1",  32'(bus.stalled_vc1),  32'(m_stall1));
    check("drop_err",     32'(bus.drop_err),     32'(m_drop));
  endtask

  task automatic idle();
    bus.in_vc0_valid = 1'b0;
    bus.in_vc1_valid = 1'b0;
    bus.in_vc0_data  = '0;
    bus.in_vc1_data  = '0;
    bus.pause_VC0    = 1'b0;
    bus.continue_VC0 = 1'b0;
    bus.pause_VC1    = 1'b0;
    bus.continue_VC1 = 1'b0;
  endtask

  // One clock: snapshot the inputs, advance the model by the channel rules, compare.
  task automatic tick();
    logic r, v0, v1, p0, c0, p1, c1, e0, e1, g, rdy0, rdy1;
    logic [BS-1:0] d0, d1;
    r  = reset;
    v0 = bus.in_vc0_valid;  d0 = bus.in_vc0_data;
    v1 = bus.in_vc1_valid;  d1 = bus.in_vc1_data;
    p0 = bus.pause_VC0;     c0 = bus.continue_VC0;
    p1 = bus.pause_VC1;     c1 = bus.continue_VC1;
    @(posedge clk);
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
      m_stall0 = 1'b0;
      m_stall1 = 1'b0;
      m_last   = 1'b1;
      m_data   = '0;
      m_valid  = 1'b0;
      m_drop   = 1'b0;
    end else begin
      rdy0 = (q0.size() < 4);
      rdy1 = (q1.size() < 4);
      e0 = (q0.size() > 0) && !m_stall0 && !p0;
      e1 = (q1.size() > 0) && !m_stall1 && !p1;
      if (e0 && e1) g = !m_last;
      else          g = e1;
      if (e0 || e1) begin
        if (!g) m_data = {1'b0, q0.pop_front()};
        else    m_data = {1'b1, q1.pop_front()};
        m_valid = 1'b1;
        m_last  = g;
      end else begin
        m_valid = 1'b0;
      end
      if (v0) begin
        if (rdy0) q0.push_back(d0);
        else      m_drop = 1'b1;
      end
      if (v1) begin
        if (rdy1) q1.push_back(d1);
        else      m_drop = 1'b1;
      end
      if (p0)      m_stall0 = 1'b1;
      else if (c0) m_stall0 = 1'b0;
      if (p1)      m_stall1 = 1'b1;
      else if (c1) m_stall1 = 1'b0;
    end
    check_all();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [BS:0] exp29 [4];
  int          out_cnt;

  initial begin
    exp29[0] = 6'h1B; exp29[1] = 6'h2D; exp29[2] = 6'h03; exp29[3] = 6'h31;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready0", 32'(bus.in_vc0_ready), 32'd1);
    check("reset_valid",  32'(bus.valid_p),      32'd0);

    // Single word through an empty FIFO: one edge of latency, then idle.
    bus.in_vc0_valid = 1'b1; bus.in_vc0_data = 5'h1B;
    tick();
    check("single_no_bypass", 32'(bus.valid_p), 32'd0);
    idle();
    tick();
    check("single_data",  32'(bus.data_p),  32'h1B);
    check("single_valid", 32'(bus.valid_p), 32'd1);
    tick();
    check("single_done", 32'(bus.valid_p), 32'd0);

    // Contention after reset: VC0 first, then strict alternation.
    do_reset();
    bus.in_vc0_valid = 1'b1; bus.in_vc0_data = 5'h1B;
    bus.in_vc1_valid = 1'b1; bus.in_vc1_data = 5'h0D;
    tick();
    bus.in_vc0_data = 5'h03; bus.in_vc1_data = 5'h11;
    tick();
    check("rr_out0", 32'(bus.data_p), 32'(exp29[0]));
    idle();
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("rr_out%0d", i), 32'(bus.data_p), 32'(exp29[i]));
      check($sformatf("rr_valid%0d", i), 32'(bus.valid_p), 32'd1);
    end
    tick();

    // Pause with three VC0 words queued, simultaneous pause+continue, then resume.
    bus.pause_VC0 = 1'b1; bus.in_vc0_valid = 1'b1; bus.in_vc0_data = 5'h05;
    tick();
    bus.pause_VC0 = 1'b0; bus.in_vc0_data = 5'h06;
    tick();
    bus.in_vc0_data = 5'h07;
    tick();
    idle();
    tick();
    check("pause_stalled", 32'(bus.stalled_vc0), 32'd1);
    check("pause_no_out",  32'(bus.valid_p),     32'd0);
    bus.pause_VC0 = 1'b1; bus.continue_VC0 = 1'b1;
    tick();
    check("pause_wins", 32'(bus.stalled_vc0), 32'd1);
    idle();
    bus.continue_VC0 = 1'b1;
    tick();
    idle();
    tick();
    check("resume_first", 32'(bus.data_p), 32'h05);
    tick();
    tick();
    check("resume_last", 32'(bus.data_p), 32'h07);

    // Overflow on VC1 while held paused.
    for (int i = 0; i < 5; i++) begin
      bus.pause_VC1    = 1'b1;
      bus.in_vc1_valid = 1'b1;
      bus.in_vc1_data  = BS'(5'h10 + i);
      tick();
      if (i == 3) check("full_ready_low", 32'(bus.in_vc1_ready), 32'd0);
    end
    idle();
    tick();
    check("drop_set", 32'(bus.drop_err), 32'd1);
    bus.continue_VC1 = 1'b1;
    tick();
    idle();
    out_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.valid_p) out_cnt++;
    end
    check("overflow_out_count", 32'(out_cnt), 32'd4);
    check("drop_sticky", 32'(bus.drop_err), 32'd1);

    // Full FIFO popped and written in the same cycle: pop wins, write refused.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.pause_VC0 = 1'b1; bus.in_vc0_valid = 1'b1; bus.in_vc0_data = BS'(5'h08 + i);
      tick();
    end
    idle();
    bus.continue_VC0 = 1'b1;
    tick();
    idle();
    bus.in_vc0_valid = 1'b1; bus.in_vc0_data = 5'h1F;
    tick();
    check("fullpop_ready", 32'(bus.in_vc0_ready), 32'd1);
    check("fullpop_drop",  32'(bus.drop_err),     32'd1);
    idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset in the middle of a queued stream.
    for (int i = 0; i < 3; i++) begin
      bus.pause_VC0 = 1'b1; bus.pause_VC1 = 1'b1;
      bus.in_vc0_valid = 1'b1; bus.in_vc0_data = BS'(5'h14 + i);
      tick();
    end
    reset = 1'b1;
    bus.in_vc1_valid = 1'b1; bus.in_vc1_data = 5'h0A;
    tick();
    reset = 1'b0;
    idle();
    check("midrst_valid", 32'(bus.valid_p),     32'd0);
    check("midrst_data",  32'(bus.data_p),      32'd0);
    check("midrst_stall", 32'(bus.stalled_vc0), 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("midrst_nothing_out", 32'(bus.valid_p), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_vc0_valid = 1'($urandom_range(0, 1));
      bus.in_vc0_data  = BS'($urandom);
      bus.in_vc1_valid = 1'($urandom_range(0, 1));
      bus.in_vc1_data  = BS'($urandom);
      bus.pause_VC0    = ($urandom_range(0, 7) == 0);
      bus.continue_VC0 = ($urandom_range(0, 3) == 0);
      bus.pause_VC1    = ($urandom_range(0, 7) == 0);
      bus.continue_VC1 = ($urandom_range(0, 3) == 0);
      reset            = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 10; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
